// File: rtl/rv32i_pkg.sv
// Shared constants for the rv32i core: memory-arbiter state encodings,
// arbiter defaults and the base opcode map used by the decode stage.
package rv32i_pkg;

    // Memory arbiter state encodings
    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    // Consecutive data grants tolerated while a fetch is waiting
    localparam int STARVE_MAX_DEF = 4;

    // RV32I base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // True for opcodes that need the data port
    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the instruction-fetch and data ports onto one unified memory
// port. Data has priority; a waiting fetch is guaranteed a slot after
// STARVE_MAX consecutive data grants. One access is in flight at a time.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ARB_IDLE   | no access in flight; arbitration happens here
// ARB_BUSY_I | fetch access issued, waiting for mem_ready
// ARB_BUSY_D | data access issued, waiting for mem_ready
module mem_arbiter
    import rv32i_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       state;
    logic [CNT_W-1:0] starve_cnt;
    logic             discard;
    logic             in_idle;
    logic             fetch_win;
    logic             data_win;

    assign in_idle   = (state == ARB_IDLE);
    assign fetch_win = in_idle & if_req & ~if_flush & ((starve_cnt == STARVE_LIM) | ~d_req);
    assign data_win  = in_idle & d_req & ~fetch_win;

    // A flush arriving in the completion cycle also cancels that fetch
    assign if_ack    = reset & (state == ARB_BUSY_I) & mem_ready & ~discard & ~if_flush;
    assign d_ack     = reset & (state == ARB_BUSY_D) & mem_ready;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign stall_if  = reset & if_req & ~if_ack;
    assign stall_mem = reset & d_req & ~d_ack;

    // Arbitration FSM and fetch-discard flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ARB_IDLE;
            discard <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (fetch_win)
                        state <= ARB_BUSY_I;
                    else if (data_win)
                        state <= ARB_BUSY_D;
                end
                ARB_BUSY_I: begin
                    if (mem_ready) begin
                        state   <= ARB_IDLE;
                        discard <= 1'b0;
                    end else if (if_flush) begin
                        discard <= 1'b1;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_ready)
                        state <= ARB_IDLE;
                end
                default: begin
                    state   <= ARB_IDLE;
                    discard <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: data grants taken while a fetch is waiting
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (fetch_win) begin
            starve_cnt <= '0;
        end else if (data_win & if_req) begin
            if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end else if (in_idle & ~if_req) begin
            starve_cnt <= '0;
        end
    end

    // Memory command register: loaded on grant, held until mem_ready
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= 4'b0000;
        end else if (fetch_win) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wmask <= 4'b0000;
        end else if (data_win) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wmask <= d_we ? d_wmask : 4'b0000;
        end else if (~in_idle & mem_ready) begin
            mem_req   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a transaction-level
// reference model (one outstanding access, starvation count as an integer).
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_ack;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [3:0]    d_wmask;
    logic          mem_req, mem_we, mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [3:0]    mem_wmask;
    logic          stall_if, stall_mem;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // stimulus controls
    bit          rst_req = 1'b1;
    int          if_left = 0, d_left = 0;
    bit          flush_once = 1'b0;
    int          flush_pct = 0, abort_pct = 0;
    int          fixed_lat = -1;
    int          wait_cnt = 0, lat_target = 0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed = '0;
    bit          flush_target_en = 1'b0;
    logic [31:0] flush_target = '0;

    // observations
    int          if_ack_cnt = 0, d_ack_cnt = 0;
    bit          ack_log[$];
    logic [31:0] last_if_rdata, last_d_rdata, last_if_addr;
    logic [3:0]  last_d_wmask;

    // reference model: one outstanding access
    bit          m_active = 0, m_fetch = 0, m_discard = 0, m_zero = 1;
    int          m_starve = 0;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [3:0]  m_wmask;

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[1:0] = 2'b00;
        return a;
    endfunction

    task automatic new_d_fields();
        d_addr  = rand_addr();
        d_we    = 1'($urandom_range(0, 1));
        d_wdata = $urandom;
        d_wmask = 4'($urandom_range(0, 15));
    endtask

    task automatic step();
        logic e_if_ack, e_d_ack, o_if_ack, o_d_ack, o_flush;
        @(negedge clk);
        reset    = ~rst_req;
        if_req   = (if_left > 0);
        d_req    = (d_left > 0);
        if_flush = flush_once || ($urandom_range(0, 99) < flush_pct);
        flush_once = 1'b0;
        if (mem_req && reset) begin
            if (wait_cnt == 0)
                lat_target = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            mem_ready = (wait_cnt >= lat_target);
        end else begin
            mem_ready = 1'b0;
        end
        mem_rdata = rd_fixed_en ? rd_fixed : $urandom;
        #1;
        e_if_ack = reset && m_active && m_fetch && mem_ready && !m_discard && !if_flush;
        e_d_ack  = reset && m_active && !m_fetch && mem_ready;
        chk("mem_req", mem_req, m_active);
        if (m_active) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_we", mem_we, m_we);
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("mem_wmask", mem_wmask, m_wmask);
        end else if (m_zero) begin
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_mem_wmask", mem_wmask, 0);
        end
        chk("if_ack", if_ack, e_if_ack);
        chk("d_ack", d_ack, e_d_ack);
        chk("stall_if", stall_if, reset && if_req && !e_if_ack);
        chk("stall_mem", stall_mem, reset && d_req && !e_d_ack);
        if (e_if_ack) chk("if_rdata", if_rdata, mem_rdata);
        if (e_d_ack)  chk("d_rdata", d_rdata, mem_rdata);

        // model next state
        if (!reset) begin
            m_active = 0; m_discard = 0; m_starve = 0; m_zero = 1;
        end else if (m_active) begin
            if (mem_ready) begin
                m_active = 0; m_discard = 0;
            end else if (m_fetch && if_flush) begin
                m_discard = 1;
            end
        end else if (if_req && !if_flush && (m_starve == SMAX || !d_req)) begin
            m_active = 1; m_fetch = 1; m_zero = 0;
            m_addr = if_addr; m_we = 0; m_wdata = 0; m_wmask = 0;
            m_starve = 0;
        end else if (d_req) begin
            m_active = 1; m_fetch = 0; m_zero = 0;
            m_addr = d_addr; m_we = d_we; m_wdata = d_wdata;
            m_wmask = d_we ? d_wmask : 4'b0000;
            m_starve = if_req ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
        end else if (!if_req) begin
            m_starve = 0;
        end

        o_if_ack = if_ack;
        o_d_ack  = d_ack;
        o_flush  = if_flush;
        if (if_ack) begin last_if_rdata = if_rdata; last_if_addr = mem_addr; end
        if (d_ack)  begin last_d_rdata = d_rdata; last_d_wmask = mem_wmask; end
        if (mem_req && !mem_ready && reset) wait_cnt++;
        else wait_cnt = 0;

        @(posedge clk);
        #1;
        if (o_if_ack) begin
            if_ack_cnt++; ack_log.push_back(1'b1);
            if (if_left > 0) if_left--;
            if_addr = rand_addr();
        end
        if (o_d_ack) begin
            d_ack_cnt++; ack_log.push_back(1'b0);
            if (d_left > 0) d_left--;
            new_d_fields();
        end
        if (o_flush) if_addr = flush_target_en ? flush_target : rand_addr();
        if (abort_pct > 0 && $urandom_range(0, 99) < abort_pct) if_left = 0;
        if (abort_pct > 0 && $urandom_range(0, 99) < abort_pct) d_left = 0;
    endtask

    int n;
    bit exp41[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        reset = 1'b0; if_req = 0; if_flush = 0; d_req = 0; mem_ready = 0;
        if_addr = '0; d_addr = '0; d_we = 0; d_wdata = '0; d_wmask = '0; mem_rdata = '0;
        @(posedge clk); #1;

        // reset with both requesters active: outputs quiet
        rst_req = 1; if_left = 1; d_left = 1;
        repeat (3) step();
        rst_req = 0; if_left = 0; d_left = 0;
        repeat (2) step();

        // lone fetch, memory answers on the third mem_req cycle
        fixed_lat = 2; rd_fixed_en = 1; rd_fixed = 32'h0000_0013;
        if_addr = 32'h40; if_left = 1; if_ack_cnt = 0;
        n = 0;
        for (int k = 0; k < 20 && if_ack_cnt == 0; k++) begin step(); n++; end
        chk("fetch_ack_cycle", n, 4);
        chk("fetch_rdata", last_if_rdata, 32'h0000_0013);
        chk("fetch_addr", last_if_addr, 32'h40);

        // simultaneous requests: store first, then fetch
        fixed_lat = 1; rd_fixed_en = 0; ack_log.delete();
        if_addr = 32'h44; if_left = 1;
        d_addr = 32'h100; d_we = 1; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'hF; d_left = 1;
        for (int k = 0; k < 30 && (if_left > 0 || d_left > 0); k++) step();
        chk("both_count", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            chk("both_first", ack_log[0], 0);
            chk("both_second", ack_log[1], 1);
        end

        // starvation: fifth grant goes to the waiting fetch
        fixed_lat = -1; ack_log.delete();
        if_left = 1; d_left = 6; new_d_fields();
        for (int k = 0; k < 100 && (if_left > 0 || d_left > 0); k++) step();
        chk("starve_count", ack_log.size(), 7);
        for (int i = 0; i < 7 && i < ack_log.size(); i++)
            chk($sformatf("starve_seq%0d", i), ack_log[i], exp41[i]);

        // flush during fetch: first fetch dropped, redirected fetch completes
        fixed_lat = 3; flush_target_en = 1; flush_target = 32'h200;
        if_addr = 32'h80; if_left = 1; if_ack_cnt = 0; last_if_addr = '0;
        for (int k = 0; k < 10 && !mem_req; k++) step();
        chk("flush_busy", mem_req, 1);
        flush_once = 1;
        for (int k = 0; k < 40 && if_ack_cnt == 0; k++) step();
        chk("flush_ack_count", if_ack_cnt, 1);
        chk("flush_refetch_addr", last_if_addr, 32'h200);
        flush_target_en = 0;

        // load: mask forced to zero, read data passed through
        fixed_lat = 1; rd_fixed_en = 1; rd_fixed = 32'h1234_5678;
        d_addr = 32'h300; d_we = 0; d_wmask = 4'hF; d_wdata = 32'hFFFF_FFFF;
        d_left = 1; d_ack_cnt = 0;
        for (int k = 0; k < 20 && d_ack_cnt == 0; k++) step();
        chk("load_acked", d_ack_cnt, 1);
        chk("load_rdata", last_d_rdata, 32'h1234_5678);
        chk("load_wmask", last_d_wmask, 0);
        rd_fixed_en = 0;

        // reset during a data access that never completes
        fixed_lat = 1000; d_left = 1; new_d_fields(); d_ack_cnt = 0;
        for (int k = 0; k < 10 && !mem_req; k++) step();
        chk("rst_busy", mem_req, 1);
        step();
        rst_req = 1; d_left = 0;
        step();
        chk("rst_abandon_req", mem_req, 0);
        rst_req = 0;
        repeat (2) step();
        chk("rst_no_ack", d_ack_cnt, 0);

        // randomized traffic
        fixed_lat = -1; flush_pct = 4; abort_pct = 2;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (if_left == 0 && $urandom_range(0, 3) == 0) begin
                if_left = $urandom_range(1, 3); if_addr = rand_addr();
            end
            if (d_left == 0 && $urandom_range(0, 2) == 0) begin
                d_left = $urandom_range(1, 6); new_d_fields();
            end
            if (c == 1500) rst_req = 1;
            if (c == 1502) rst_req = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
